// File: rtl/sync_fifo_unpacker_rd.sv
// Read-side drain controller: pulls bytes from a sync FIFO, packs PACK of them per word and
// queues words on a valid/ready stream. Optional idle auto-flush under RD_TIMEOUT_FLUSH_EN.
module sync_fifo_unpacker_rd #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned PACK          = 4,
  parameter int unsigned FLUSH_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       fifo_empty,
  output logic                       fifo_rd_en,
  input  logic                       fifo_rd_vld,
  input  logic [DATA_WIDTH-1:0]      fifo_data,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH*PACK-1:0] out_data,
  output logic [PACK-1:0]            out_keep,
  output logic                       busy
);

  localparam int unsigned WordW = DATA_WIDTH * PACK;
  localparam int unsigned CntW  = $clog2(PACK + 1);

  if (PACK < 2 || PACK > 8 || FLUSH_TIMEOUT < 1) begin : g_bad_cfg
    $error("sync_fifo_unpacker_rd: unsupported parameter set");
  end

  logic [CntW-1:0]  cnt_q;
  logic             inflight_q;
  logic             flush_pending_q;
  logic [WordW-1:0] pack_q;
  logic [WordW-1:0] q_data_q [2];
  logic [PACK-1:0]  q_keep_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       qcnt_q;

  logic             capture, last_byte, pop, push, flush_done, flush_set, tmo_hit;
  logic [WordW-1:0] pack_merged, push_data;
  logic [PACK-1:0]  flush_keep, push_keep;

  assign capture   = fifo_rd_vld && !rstn;
  assign last_byte = capture && (cnt_q == CntW'(PACK - 1));
  assign out_valid = (qcnt_q != 2'd0);
  assign pop       = out_valid && out_ready;

  // A partial word may meet a full queue; completion then waits for a free slot.
  assign flush_done = flush_pending_q && !inflight_q && !capture &&
                      ((cnt_q == '0) || (qcnt_q < 2'd2) || pop);

  assign push      = last_byte || (flush_done && (cnt_q != '0));
  assign push_data = last_byte ? pack_merged : pack_q;
  assign push_keep = last_byte ? {PACK{1'b1}} : flush_keep;
  assign flush_set = flush || tmo_hit;

  assign fifo_rd_en = !rstn && !fifo_empty && !flush_pending_q &&
                      ((cnt_q + CntW'(inflight_q)) < CntW'(PACK)) && (qcnt_q < 2'd2);

  assign out_data = q_data_q[rd_ptr_q];
  assign out_keep = q_keep_q[rd_ptr_q];
  assign busy     = (cnt_q != '0) || inflight_q || (qcnt_q != 2'd0) || flush_pending_q;

  always_comb begin
    pack_merged = pack_q;
    flush_keep  = '0;
    for (int i = 0; i < int'(PACK); i++) begin
      if (cnt_q == CntW'(i)) pack_merged[i*DATA_WIDTH +: DATA_WIDTH] = fifo_data;
      flush_keep[i] = (CntW'(i) < cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      cnt_q           <= '0;
      inflight_q      <= 1'b0;
      flush_pending_q <= 1'b0;
      pack_q          <= '0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      qcnt_q          <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        q_data_q[i] <= '0;
        q_keep_q[i] <= '0;
      end
    end else begin
      inflight_q <= fifo_rd_en;

      if (capture) begin
        if (last_byte) begin
          cnt_q  <= '0;
          pack_q <= '0;
        end else begin
          cnt_q  <= cnt_q + 1'b1;
          pack_q <= pack_merged;
        end
      end else if (flush_done) begin
        cnt_q  <= '0;
        pack_q <= '0;
      end

      // A flush pulse landing while one is already pending is absorbed.
      if (flush_done)     flush_pending_q <= 1'b0;
      else if (flush_set) flush_pending_q <= 1'b1;

      if (push) begin
        q_data_q[wr_ptr_q] <= push_data;
        q_keep_q[wr_ptr_q] <= push_keep;
        wr_ptr_q           <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;

      if (push && !pop)      qcnt_q <= qcnt_q + 2'd1;
      else if (pop && !push) qcnt_q <= qcnt_q - 2'd1;
    end
  end

`ifdef RD_TIMEOUT_FLUSH_EN
  localparam int unsigned TmoW = $clog2(FLUSH_TIMEOUT + 1);

  logic [TmoW-1:0] tmo_q;

  assign tmo_hit = (tmo_q == TmoW'(FLUSH_TIMEOUT));

  always_ff @(posedge clk) begin
    if (rstn) begin
      tmo_q <= '0;
    end else if (capture || flush_done || !fifo_empty) begin
      tmo_q <= '0;
    end else if ((cnt_q != '0) && !inflight_q && !tmo_hit) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

endmodule

// File: doc/sync_fifo_unpacker_rd.md
Name: sync_fifo_unpacker_rd

Overview:
Read-side drain controller for the team's 8-bit synchronous FIFO. It watches fifo_empty, issues fifo_rd_en, and captures bytes returned with fifo_rd_vld one cycle later. It packs PACK consecutive bytes into one wide word and presents that word on a valid/ready stream through a 2-entry output queue. Partial words leave on explicit flush, or on idle timeout when the optional feature is compiled in.

Parameters:
DATA_WIDTH, 8, FIFO byte width.
PACK, 4, bytes per output word (2..8).
FLUSH_TIMEOUT, 16, idle cycles before auto-flush; used only with RD_TIMEOUT_FLUSH_EN.

Ports:
clk  in  1  sole clock, rising edge.
rstn  in  1  reset; synchronous, active-high (1 = in reset).
fifo_empty  in  1  FIFO empty flag.
fifo_rd_en  out  1  FIFO read request.
fifo_rd_vld  in  1  FIFO read data valid, one cycle after fifo_rd_en.
fifo_data  in  DATA_WIDTH  FIFO read data.
flush  in  1  single-cycle pulse; emit the partial word.
out_valid  out  1  output word valid.
out_ready  in  1  downstream accept.
out_data  out  DATA_WIDTH*PACK  packed word; first byte in bits [7:0].
out_keep  out  PACK  byte enables; bit i qualifies byte i.
busy  out  1  any byte or word held or in flight.

Behaviour:
- One clock; reset is synchronous and active-high. The block shares rstn with the FIFO.
- Reset clears cnt, inflight, flush_pending, the packer register and the queue. Reset values: fifo_rd_en=0, out_valid=0, out_data=0, out_keep=0, busy=0. fifo_rd_vld is ignored in any cycle where rstn=1.
- State:
  - cnt (0..PACK-1): bytes held in the packer.
  - inflight: registered fifo_rd_en.
  - qcnt (0..2): entries in the output queue.
  - flush_pending: flush requested, not yet completed.
- fifo_rd_en (combinational): !rstn && !fifo_empty && !flush_pending && (cnt+inflight)<PACK && qcnt<2.
- Because qcnt<2 is checked at every issue, the queue always has space when a word completes.
- Throughput: one idle cycle per word (PACK reads, then 1 bubble); sustained rate is PACK bytes per PACK+1 cycles.
- Capture: when fifo_rd_vld=1, write fifo_data into byte lane cnt and increment cnt.
  - If cnt was PACK-1, push {packer, keep=all ones} into the queue in the same cycle and set cnt=0.
  - The packer is cleared to 0 on every push.
- Flush:
  - A flush pulse sets flush_pending. A flush pulse while flush_pending=1 is absorbed.
  - While pending, no reads are issued.
  - Flush completes in the first cycle with inflight=0 and no capture. If cnt>0, push the packer with keep=(1<<cnt)-1 (unused bytes zero) and set cnt=0. If cnt=0, push nothing. flush_pending then clears.
  - A flush arriving while the last byte of a word is in flight: that full word is pushed first; the flush then completes with cnt=0 and pushes nothing.
- Queue:
  - 2-entry FIFO; out_valid = qcnt!=0; out_data/out_keep show the head entry.
  - The head is stable while out_valid && !out_ready.
  - Pop on out_valid && out_ready. Push and pop in the same cycle leave qcnt unchanged.
- busy = cnt!=0 || inflight || qcnt!=0 || flush_pending.
- Reset mid-operation: all held and in-flight bytes are discarded with no output. After reset releases, nothing is emitted until new reads complete.

Optional Feature:
RD_TIMEOUT_FLUSH_EN
- Defined:
  - A counter of width clog2(FLUSH_TIMEOUT+1) increments each cycle that cnt>0 && inflight=0 && fifo_empty=1.
  - It clears on capture, flush completion, reset, or any cycle where fifo_empty=0.
  - When the counter reaches FLUSH_TIMEOUT, flush_pending is set internally, exactly as if flush had pulsed.
- Undefined: the counter logic is absent; partial words leave only via the flush port.

Test Plan:
- PACK=4, out_ready=1, FIFO loaded with 0x11,0x22,0x33,0x44 -> one beat: out_data=0x44332211, out_keep=0xF; fifo_rd_en high for 4 consecutive cycles.
- out_ready=0, 12 bytes loaded -> exactly 8 reads issued, qcnt=2, fifo_rd_en stays 0 and 4 bytes remain in the FIFO. Raising out_ready then drains 3 words in order with no loss.
- 3 bytes 0xA1,0xA2,0xA3, then a flush pulse -> out_data=0x00A3A2A1, out_keep=0x7; busy=0 afterwards. A second flush with cnt=0 -> no beat.
- Flush pulsed in the same cycle fifo_rd_en issues the 4th byte 0x44 -> one full beat 0x44332211 keep 0xF; no extra partial beat.
- rstn=1 for 1 cycle with 2 bytes held and 1 in flight -> no output beat, busy=0 next cycle; 4 new bytes afterwards form a clean word.
- With RD_TIMEOUT_FLUSH_EN and FLUSH_TIMEOUT=16: 1 byte 0x5A, FIFO left empty -> after 16 idle cycles, beat out_data=0x0000005A, out_keep=0x1. Without the macro -> no beat.
